// File: rtl/fetch_buffer_pkg.sv
// Shared core definitions for the fetch front-end: widths, reset PC, NOP encoding and
// the {pc, inst} entry carried from fetch to decode.
package fetch_buffer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; low two bits of a jump target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush, push/pop, occupancy count and head read.
// The caller must not push when full without a pop, nor pop when empty.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer and occupancy update; flush empties the queue and ignores push/pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front-end: owns the PC, addresses imem, and queues fetched
// {pc, inst} pairs for decode. A redirect flushes the queue and restarts fetch.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_data,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [XLEN-1:0]            dec_inst,
  output logic [XLEN-1:0]            dec_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q;
  logic            push;
  logic            pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;

  assign imem_addr = fetch_pc_q;
  assign dec_valid = (count != '0);

  // A full queue still accepts a new entry when decode drains the head this cycle.
  assign pop  = dec_valid && dec_ready;
  assign push = !redirect && ((count < DepthCnt) || pop);

  assign wr_entry = '{pc: fetch_pc_q, inst: imem_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .head  (head_entry),
    .count (count)
  );

  // PC register: reset > redirect > advance on push; holds while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_q <= align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc_q <= fetch_pc_q + 32'd4;
    end
  end

  // Present the head entry, or a NOP at PC 0 when the queue is empty.
  always_comb begin
    dec_inst = NOP_INST;
    dec_pc   = '0;
    if (dec_valid) begin
      dec_inst = head_entry.inst;
      dec_pc   = head_entry.pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a queue-based model.
module tb_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC   = 32'h0100_0000;
  localparam logic [31:0] MASK  = 32'hA5A5_A5A5;

  logic          clock = 1'b0;
  logic          reset;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_data;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_inst;
  logic [31:0]   dec_pc;
  logic [CW-1:0] count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Behavioural model: the queue of pending {pc, inst} and the next fetch address.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  always #5 clock = ~clock;

  // Instruction memory stand-in.
  assign imem_data = imem_addr ^ MASK;

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .count       (count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Compare every observable output against the model.
  task automatic model_compare();
    logic [63:0] h;
    chk("imem_addr", imem_addr, m_pc);
    chk("count", 32'(count), 32'(m_q.size()));
    chk("dec_valid", 32'(dec_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      h = m_q[0];
      chk("dec_pc", dec_pc, h[63:32]);
      chk("dec_inst", dec_inst, h[31:0]);
    end else begin
      chk("dec_pc_empty", dec_pc, 32'h0);
      chk("dec_inst_empty", dec_inst, 32'h0000_0013);
    end
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_step();
    bit do_pop, do_push;
    if (reset) begin
      m_q.delete();
      m_pc = RPC;
    end else if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      do_pop  = (m_q.size() != 0) && dec_ready;
      do_push = (m_q.size() < DEPTH) || do_pop;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({m_pc, m_pc ^ MASK});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle();
    model_compare();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; dec_ready = 1'b0; redirect_pc = '0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    @(posedge clock);
    model_step();
    #1;
    cycle();

    // Reset state, then streaming one per cycle.
    chk("rst_imem_addr", imem_addr, 32'h0100_0000);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_inst", dec_inst, 32'h0000_0013);
    chk("rst_dec_pc", dec_pc, 32'h0);
    reset = 1'b0; dec_ready = 1'b1;
    cycle();
    chk("first_valid", 32'(dec_valid), 32'd1);
    chk("first_pc", dec_pc, 32'h0100_0000);
    chk("first_inst", dec_inst, 32'h0100_0000 ^ 32'hA5A5_A5A5);
    cycle();
    chk("stream_pc1", dec_pc, 32'h0100_0004);
    cycle();
    chk("stream_pc2", dec_pc, 32'h0100_0008);

    // Stall until full, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) cycle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_imem_addr", imem_addr, 32'h0100_0010);
    dec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", dec_pc, 32'h0100_0000 + 32'(4 * k));
      cycle();
    end

    // Redirect with three entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    chk("pre_redir_count", 32'(count), 32'd3);
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0100_0103;
    cycle();
    redirect = 1'b0;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(dec_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h0100_0100);
    cycle();
    chk("redir_pc", dec_pc, 32'h0100_0100);

    // Reset wins over redirect.
    dec_ready = 1'b1; reset = 1'b1; redirect = 1'b1; redirect_pc = 32'hDEAD_BEEF;
    cycle();
    chk("rst_redir_addr", imem_addr, 32'h0100_0000);
    chk("rst_redir_count", 32'(count), 32'd0);
    reset = 1'b0; redirect = 1'b0;
    cycle();
    chk("rst_redir_pc", dec_pc, 32'h0100_0000);

    // Full with concurrent push and pop: occupancy stays at DEPTH, PCs consecutive.
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("steady_count", 32'(count), 32'd4);
      chk("steady_pc", dec_pc, 32'h0100_0000 + 32'(4 * (i + 1)));
    end

    // PC wraps at the top of the address space.
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc0", dec_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc1", dec_pc, 32'h0000_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      dec_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      reset       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; redirect = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
